// File: rtl/led_matrix_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_ctrl_pkg
// Shared definitions for the 4x8 tri-colour LED matrix scan controller.
//   - Colour constants (3-bit R/G/B) and colour bit indices.
//   - Matrix geometry.
//   - Scan FSM state encoding.
//   - Helpers: counter width sizing and active-low column one-hot decode.
// No ports (package).
// -----------------------------------------------------------------------------
package led_matrix_scan_ctrl_pkg;

    localparam int MATRIX_COLS = 4;
    localparam int MATRIX_ROWS = 8;
    localparam int COL_BITS    = 3 * MATRIX_ROWS;

    // Colour bit positions inside one 3-bit pixel.
    localparam int CLR_R = 2;
    localparam int CLR_G = 1;
    localparam int CLR_B = 0;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // Width needed to hold values 0..n-1; never narrower than one bit so a
    // degenerate count of 1 still yields a legal vector.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Active-low one-hot enable for the given column.
    function automatic logic [MATRIX_COLS-1:0] col_enable_n(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_ctrl_if
// Bundles the game-controller side (column data, brightness, blink request)
// and the panel side (column enables, row drives, scan status) of the scan
// controller.
//   column_0..3  24  colour data, bits [3k+2:3k] = row 7-k (R,G,B)
//   brightness    3  PWM level, 0 = 1/8 duty .. 7 = full duty
//   blink_en      1  blink the panel (game over)
//   col_en_n      4  one-hot active-low column enable
//   row_r/g/b     8  row drives, active-high, bit r = row r (row 0 = top)
//   scan_col      2  column currently being driven/blanked
//   frame_start   1  one-cycle pulse per frame
// There is no valid/ready handshake: the inputs are level signals that the
// controller samples once per frame in its LOAD cycle; frame_start marks the
// cycle right after that sample, so a producer may update anything it likes
// until the next sample without tearing the frame being shown.
// modport master: game controller / testbench side.
// modport slave : scan controller side.
// -----------------------------------------------------------------------------
interface led_matrix_scan_ctrl_if;
    import led_matrix_scan_ctrl_pkg::*;

    logic [COL_BITS-1:0]    column_0;
    logic [COL_BITS-1:0]    column_1;
    logic [COL_BITS-1:0]    column_2;
    logic [COL_BITS-1:0]    column_3;
    logic [2:0]             brightness;
    logic                   blink_en;

    logic [MATRIX_COLS-1:0] col_en_n;
    logic [MATRIX_ROWS-1:0] row_r;
    logic [MATRIX_ROWS-1:0] row_g;
    logic [MATRIX_ROWS-1:0] row_b;
    logic [1:0]             scan_col;
    logic                   frame_start;

    modport master (
        output column_0, column_1, column_2, column_3, brightness, blink_en,
        input  col_en_n, row_r, row_g, row_b, scan_col, frame_start
    );

    modport slave (
        input  column_0, column_1, column_2, column_3, brightness, blink_en,
        output col_en_n, row_r, row_g, row_b, scan_col, frame_start
    );

endinterface

// File: rtl/led_matrix_scan_ctrl_slot_timer.sv
// -----------------------------------------------------------------------------
// scan_slot_timer
// Times the BLANK gap and the DRIVE window of one column.
//   clk          in  1  clock
//   rst_n        in  1  asynchronous active-low reset
//   blank_start  in  1  strobe: begin a BLANK_CYCLES gap from the next clock
//   drive_start  in  1  strobe: begin an 8*SLOT_CYCLES drive window
//   blank_done   out 1  high in the last clock of the gap
//   drive_done   out 1  high in the last clock of the drive window
//   slot         out 3  PWM slot index 0..7 within the drive window
// Counters stop at their terminal counts and only restart on a start strobe.
// -----------------------------------------------------------------------------
module scan_slot_timer
    import led_matrix_scan_ctrl_pkg::*;
#(
    parameter int SLOT_CYCLES  = 1560,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       blank_start,
    input  logic       drive_start,
    output logic       blank_done,
    output logic       drive_done,
    output logic [2:0] slot
);

    localparam int PW = width_of(SLOT_CYCLES);
    localparam int BW = width_of(BLANK_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SLOT_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blank_cnt;
    logic          blank_active;
    logic          drive_active;
    logic          slot_end;

    assign blank_done = blank_active && (blank_cnt == BLANK_LAST);
    assign slot_end   = drive_active && (pre_cnt == PRE_LAST);
    assign drive_done = slot_end && (slot == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_active <= 1'b0;
            blank_cnt    <= '0;
            drive_active <= 1'b0;
            pre_cnt      <= '0;
            slot         <= '0;
        end else begin
            if (blank_start) begin
                blank_active <= 1'b1;
                blank_cnt    <= '0;
            end else if (blank_done) begin
                blank_active <= 1'b0;
            end else if (blank_active) begin
                blank_cnt <= blank_cnt + 1'b1;
            end

            if (drive_start) begin
                drive_active <= 1'b1;
                pre_cnt      <= '0;
                slot         <= '0;
            end else if (drive_done) begin
                drive_active <= 1'b0;
            end else if (slot_end) begin
                pre_cnt <= '0;
                slot    <= slot + 3'd1;
            end else if (drive_active) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_ctrl
// Scan scheduler for the 4x8 tri-colour LED matrix. Snapshots the four column
// buses once per frame, then drives the panel one column at a time with a
// blanking gap before each column, 8-level PWM brightness and an optional
// game-over blink.
//   CLK_50M    in  1   system clock
//   RST_N      in  1   asynchronous active-low reset
//   bus        slave modport of led_matrix_scan_ctrl_if (data in, panel out)
//   state_dbg  out     current scan FSM state
// All panel outputs are registered and show the internal scan state one
// clock later, so frame_start lands in the cycle after LOAD and each column's
// enables and row bits always switch on the same edge.
// -----------------------------------------------------------------------------
module led_matrix_scan_ctrl
    import led_matrix_scan_ctrl_pkg::*;
#(
    parameter int SLOT_CYCLES  = 1560,
    parameter int BLANK_CYCLES = 50,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                    CLK_50M,
    input  logic                    RST_N,
    led_matrix_scan_ctrl_if.slave   bus,
    output scan_state_e             state_dbg
);

    localparam int KW = width_of(BLINK_FRAMES + 1);
    localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_FRAMES - 1);

    scan_state_e            state;
    logic [1:0]             col;
    logic [COL_BITS-1:0]    shadow [MATRIX_COLS];
    logic [2:0]             sh_bright;
    logic                   sh_dark;      // this frame is a blink-off frame
    logic [KW-1:0]          blink_cnt;
    logic                   phase;

    logic                   blank_start;
    logic                   drive_start;
    logic                   blank_done;
    logic                   drive_done;
    logic [2:0]             slot;

    logic [COL_BITS-1:0]    cur_col;
    logic [MATRIX_ROWS-1:0] pix_r;
    logic [MATRIX_ROWS-1:0] pix_g;
    logic [MATRIX_ROWS-1:0] pix_b;
    logic                   lit;

    assign state_dbg = state;

    // A gap precedes every column: after LOAD for column 0, after each
    // drive window for columns 1..3.
    assign blank_start = (state == ST_LOAD) ||
                         ((state == ST_DRIVE) && drive_done && (col != 2'd3));
    assign drive_start = (state == ST_BLANK) && blank_done;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (CLK_50M),
        .rst_n        (RST_N),
        .blank_start  (blank_start),
        .drive_start  (drive_start),
        .blank_done   (blank_done),
        .drive_done   (drive_done),
        .slot         (slot)
    );

    // Column word bits [3k+2:3k] hold row 7-k, so row r sits at k = 7-r.
    assign cur_col = shadow[col];
    for (genvar r = 0; r < MATRIX_ROWS; r++) begin : g_row
        assign pix_r[r] = cur_col[3*(MATRIX_ROWS-1-r) + CLR_R];
        assign pix_g[r] = cur_col[3*(MATRIX_ROWS-1-r) + CLR_G];
        assign pix_b[r] = cur_col[3*(MATRIX_ROWS-1-r) + CLR_B];
    end

    // PWM: slots 0..brightness are on, so level 0 still shows 1/8 duty.
    assign lit = (slot <= sh_bright) && !sh_dark;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state           <= ST_LOAD;
            col             <= '0;
            shadow          <= '{default: '0};
            sh_bright       <= '0;
            sh_dark         <= 1'b0;
            blink_cnt       <= '0;
            phase           <= 1'b0;
            bus.col_en_n    <= '1;
            bus.row_r       <= '0;
            bus.row_g       <= '0;
            bus.row_b       <= '0;
            bus.scan_col    <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            // Registered panel view of the current internal state.
            bus.frame_start <= (state == ST_LOAD);
            bus.scan_col    <= (state == ST_LOAD) ? 2'd0 : col;
            if (state == ST_DRIVE) begin
                bus.col_en_n <= col_enable_n(col);
                bus.row_r    <= lit ? pix_r : '0;
                bus.row_g    <= lit ? pix_g : '0;
                bus.row_b    <= lit ? pix_b : '0;
            end else begin
                bus.col_en_n <= '1;
                bus.row_r    <= '0;
                bus.row_g    <= '0;
                bus.row_b    <= '0;
            end

            case (state)
                ST_LOAD: begin
                    shadow[0] <= bus.column_0;
                    shadow[1] <= bus.column_1;
                    shadow[2] <= bus.column_2;
                    shadow[3] <= bus.column_3;
                    sh_bright <= bus.brightness;
                    // The frame shows the phase held before this LOAD's
                    // update, giving BLINK_FRAMES lit then BLINK_FRAMES dark.
                    sh_dark   <= bus.blink_en & phase;
                    col       <= 2'd0;
                    if (bus.blink_en) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            phase     <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end else begin
                        blink_cnt <= '0;
                        phase     <= 1'b0;
                    end
                    state <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (drive_done) begin
                        if (col == 2'd3) begin
                            state <= ST_LOAD;
                        end else begin
                            col   <= col + 2'd1;
                            state <= ST_BLANK;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scan_ctrl
// Directed bench for led_matrix_scan_ctrl with SLOT_CYCLES=2, BLANK_CYCLES=1,
// BLINK_FRAMES=2. A frame is the frame_start cycle plus 68 captured cycles:
// index 17c is column c's blank clock, 17c+1 .. 17c+16 its drive window.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan_ctrl;
    import led_matrix_scan_ctrl_pkg::*;

    localparam int SLOT      = 2;
    localparam int BLANK     = 1;
    localparam int BF        = 2;
    localparam int FRAME_LEN = 4 * (BLANK + 8 * SLOT);

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    scan_state_e state_dbg;

    always #10 clk = ~clk;

    led_matrix_scan_ctrl_if bus ();

    led_matrix_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK_50M   (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- frame capture ----------------
    logic [3:0] cap_en [FRAME_LEN];
    logic [7:0] cap_r  [FRAME_LEN];
    logic [7:0] cap_g  [FRAME_LEN];
    logic [7:0] cap_b  [FRAME_LEN];
    logic [1:0] cap_sc [FRAME_LEN];
    logic       cap_fs [FRAME_LEN];

    int blink_exp [6] = '{24, 24, 0, 0, 24, 24};

    task automatic wait_fs(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.frame_start !== 1'b1 && waited < 200);
        if (bus.frame_start !== 1'b1) check("frame_start_timeout", bus.frame_start, 1);
    endtask

    // Capture one frame; at index chg_at apply one input change
    // (what: 1 = column_1, 2 = brightness, 3 = blink_en).
    task automatic capture(input int chg_at, input int what, input logic [23:0] val);
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            cap_en[i] = bus.col_en_n;
            cap_r[i]  = bus.row_r;
            cap_g[i]  = bus.row_g;
            cap_b[i]  = bus.row_b;
            cap_sc[i] = bus.scan_col;
            cap_fs[i] = bus.frame_start;
            if (i == chg_at) begin
                case (what)
                    1: bus.column_1   = val;
                    2: bus.brightness = val[2:0];
                    3: bus.blink_en   = val[0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic frame(input int chg_at, input int what, input logic [23:0] val);
        int w;
        wait_fs(w);
        capture(chg_at, what, val);
    endtask

    function automatic int lit_cnt(input int first, input int len);
        int n = 0;
        for (int i = first; i < first + len; i++)
            if ((cap_r[i] | cap_g[i] | cap_b[i]) != 8'h00) n++;
        return n;
    endfunction

    function automatic int en_cnt(input int first, input int len, input logic [3:0] v);
        int n = 0;
        for (int i = first; i < first + len; i++)
            if (cap_en[i] == v) n++;
        return n;
    endfunction

    function automatic int fs_cnt();
        int n = 0;
        for (int i = 0; i < FRAME_LEN; i++)
            if (cap_fs[i]) n++;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int w;
        bus.column_0   = 24'hE00000;
        bus.column_1   = 24'h000000;
        bus.column_2   = 24'h000001;
        bus.column_3   = 24'h000000;
        bus.brightness = 3'd7;
        bus.blink_en   = 1'b0;

        // 1: reset state and first-frame timing
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_en_n", bus.col_en_n, 4'hF);
        check("rst_rows", {bus.row_r, bus.row_g, bus.row_b}, 24'h0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_scan_col", bus.scan_col, 0);
        check("rst_state", state_dbg, ST_LOAD);
        rst_n = 1'b1;
        wait_fs(w);
        check("fs_latency", w, 1);
        check("fs_dark", bus.col_en_n, 4'hF);
        capture(-1, 0, 24'h0);
        check("t1_blank0", cap_en[0], 4'hF);
        check("t1_col0_window", en_cnt(1, 16, 4'hE), 16);
        check("t1_blank1", cap_en[17], 4'hF);
        check("t1_col1_start", cap_en[18], 4'hD);
        check("t1_col3_window", en_cnt(52, 16, 4'h7), 16);
        check("t1_scan_col1", cap_sc[17], 1);
        check("t1_fs_single", fs_cnt(), 0);

        // 2: pixel mapping
        check("t2_c0_r", cap_r[1], 8'h01);
        check("t2_c0_g", cap_g[1], 8'h01);
        check("t2_c0_b", cap_b[1], 8'h01);
        check("t2_c2_b", cap_b[35], 8'h80);
        check("t2_c2_rg", {cap_r[35], cap_g[35]}, 16'h0);
        check("t2_c0_lit", lit_cnt(1, 16), 16);

        // 3: snapshot - column_1 changes during col0 drive
        frame(5, 1, 24'hFFFFFF);
        check("t3_c1_dark", lit_cnt(18, 16), 0);
        check("t3_c0_lit", lit_cnt(1, 16), 16);
        frame(5, 2, 24'd0);           // brightness -> 0 mid-frame
        check("t3_c1_lit", lit_cnt(18, 16), 16);
        check("t3_c1_r", cap_r[18], 8'hFF);
        check("t4_bright_deferred", lit_cnt(1, 16), 16);

        // 4: PWM levels
        frame(5, 2, 24'd3);           // brightness -> 3 mid-frame
        check("t4_b0_c0", lit_cnt(1, 16), 2);
        check("t4_b0_c1", lit_cnt(18, 16), 2);
        check("t4_b0_slot0", cap_r[2], 8'h01);
        check("t4_b0_slot1_dark", cap_r[3], 8'h00);
        check("t4_b0_slot1_en", cap_en[3], 4'hE);
        frame(5, 3, 24'd1);           // blink_en -> 1 mid-frame
        check("t4_b3_total", lit_cnt(0, FRAME_LEN), 24);
        check("t4_b3_c2", lit_cnt(35, 16), 8);

        // 5: blink, two lit / two dark frames, then blink off
        for (int f = 0; f < 6; f++) begin
            if (f == 5) frame(5, 3, 24'd0);
            else        frame(-1, 0, 24'd0);
            check($sformatf("t5_blink_f%0d", f + 1), lit_cnt(0, FRAME_LEN), blink_exp[f]);
            check($sformatf("t5_scan_f%0d", f + 1), en_cnt(52, 16, 4'h7), 16);
        end
        frame(-1, 0, 24'd0);
        check("t5_blink_off", lit_cnt(0, FRAME_LEN), 24);

        // 6: reset during col2 drive
        wait_fs(w);
        repeat (40) @(negedge clk);
        check("t6_pre_en", bus.col_en_n, 4'hB);
        check("t6_pre_b", bus.row_b, 8'h80);
        rst_n = 1'b0;
        #1;
        check("t6_rst_en", bus.col_en_n, 4'hF);
        check("t6_rst_rows", {bus.row_r, bus.row_g, bus.row_b}, 24'h0);
        check("t6_rst_state", state_dbg, ST_LOAD);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(w);
        check("t6_fs_latency", w, 1);
        check("t6_fs_scan_col", bus.scan_col, 0);
        capture(-1, 0, 24'h0);
        check("t6_col0_restart", cap_en[1], 4'hE);
        check("t6_col0_lit", lit_cnt(1, 16), 8);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
